// File: rtl/pwl_synth_pkg.sv
// Shared defaults and FSM state encoding for the PWL synth audio output path.
// No logic here; imported by the mixer and its PWM back end.
package pwl_synth_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_SAMPLE_BITS  = 10;
    localparam int DEF_PWM_BITS     = DEF_SAMPLE_BITS + $clog2(DEF_NUM_CHANNELS);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mix_state_e;

endpackage

// File: rtl/pwl_pwm_dac.sv
// Free-running PWM counter and comparator with a wrap-aligned duty register.
// pwm_out is registered (one cycle behind the counter); duty_load is honoured only on the wrap cycle.
module pwl_pwm_dac
    import pwl_synth_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                duty_load,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out,
    output logic                wrap
);

    localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_q;

    assign wrap    = &cnt_q;
    assign pwm_out = pwm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            duty_q <= MID;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            pwm_q <= (cnt_q < duty_q);
            // Swapping duty only as the counter rolls over keeps each period intact.
            if (duty_load && wrap) begin
                duty_q <= duty;
            end
        end
    end

endmodule

// File: rtl/pwl_output_mixer.sv
// Sums one signed sample per channel into a frame and hands it, offset-binary, to the PWM DAC.
// Frames must arrive in channel order; in_ready drops while a finished frame waits for the next wrap.
module pwl_output_mixer
    import pwl_synth_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int SAMPLE_BITS  = DEF_SAMPLE_BITS,
    parameter int PWM_BITS     = DEF_PWM_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_channel,
    input  logic [SAMPLE_BITS-1:0] in_sample,
    output logic                   pwm_out,
    output logic [PWM_BITS-1:0]    out_sample,
    output logic                   out_tick,
    output logic                   seq_error
);

    localparam int                  EXT     = PWM_BITS - SAMPLE_BITS;
    localparam logic [1:0]          LAST_CH = 2'(NUM_CHANNELS - 1);
    localparam logic [PWM_BITS-1:0] MID     = {1'b1, {(PWM_BITS-1){1'b0}}};

    mix_state_e          state_q;
    logic [PWM_BITS-1:0] acc_q;
    logic [PWM_BITS-1:0] pending_q;
    logic [PWM_BITS-1:0] out_sample_q;
    logic [1:0]          next_ch_q;
    logic                tick_q;
    logic                seq_err_q;

    logic [PWM_BITS-1:0] sample_ext;
    logic [PWM_BITS-1:0] sum_d;
    logic                xfer;
    logic                wrap;

    assign sample_ext = {{EXT{in_sample[SAMPLE_BITS-1]}}, in_sample};
    assign sum_d      = acc_q + sample_ext;
    assign in_ready   = (state_q == ACCUM);
    assign xfer       = in_valid && in_ready;

    assign out_sample = out_sample_q;
    assign out_tick   = tick_q;
    assign seq_error  = seq_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            pending_q    <= '0;
            out_sample_q <= MID;
            next_ch_q    <= '0;
            tick_q       <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (xfer) begin
                if (in_channel == next_ch_q) begin
                    if (next_ch_q == LAST_CH) begin
                        // Flipping the sign bit maps two's complement onto an unsigned duty.
                        pending_q <= {~sum_d[PWM_BITS-1], sum_d[PWM_BITS-2:0]};
                        acc_q     <= '0;
                        next_ch_q <= '0;
                        state_q   <= HOLD;
                    end else begin
                        acc_q     <= sum_d;
                        next_ch_q <= next_ch_q + 2'd1;
                    end
                end else begin
                    seq_err_q <= 1'b1;
                    if (in_channel == 2'd0) begin
                        acc_q     <= sample_ext;
                        next_ch_q <= 2'd1;
                    end else begin
                        acc_q     <= '0;
                        next_ch_q <= '0;
                    end
                end
            end
            if ((state_q == HOLD) && wrap) begin
                out_sample_q <= pending_q;
                tick_q       <= 1'b1;
                state_q      <= ACCUM;
            end
        end
    end

    pwl_pwm_dac #(
        .PWM_BITS (PWM_BITS)
    ) u_dac (
        .clk       (clk),
        .reset     (reset),
        .duty_load (state_q == HOLD),
        .duty      (pending_q),
        .pwm_out   (pwm_out),
        .wrap      (wrap)
    );

endmodule

// File: tb/tb_pwl_output_mixer.sv
// Directed bench for the output mixer: frame summing, wrap-aligned duty hand-off, sequencing errors, reset.
module tb_pwl_output_mixer;

    localparam int NC = 4;
    localparam int SB = 10;
    localparam int PB = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    in_channel = 2'd0;
    logic [SB-1:0] in_sample = '0;
    logic          in_ready;
    logic          pwm_out;
    logic [PB-1:0] out_sample;
    logic          out_tick;
    logic          seq_error;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pwl_output_mixer #(
        .NUM_CHANNELS (NC),
        .SAMPLE_BITS  (SB),
        .PWM_BITS     (PB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_channel (in_channel),
        .in_sample  (in_sample),
        .pwm_out    (pwm_out),
        .out_sample (out_sample),
        .out_tick   (out_tick),
        .seq_error  (seq_error)
    );

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [1:0] ch, input int s);
        int n;
        n = 0;
        in_valid   = 1'b1;
        in_channel = ch;
        in_sample  = SB'(s);
        while (!in_ready && n < 9000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 9000) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int s0, input int s1, input int s2, input int s3);
        send(2'd0, s0);
        send(2'd1, s1);
        send(2'd2, s2);
        send(2'd3, s3);
    endtask

    task automatic wait_tick(output int ready_cycles);
        logic seen;
        seen = 1'b0;
        ready_cycles = 0;
        for (int n = 0; n < 9000; n++) begin
            @(negedge clk);
            if (out_tick) begin
                seen = 1'b1;
                break;
            end
            if (in_ready) ready_cycles++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL tick_timeout: out_tick got 0, required 1 within 9000 cycles");
        end
    endtask

    task automatic count_high(output int c);
        c = 0;
        repeat (4096) begin
            @(negedge clk);
            if (pwm_out) c++;
        end
    endtask

    task automatic test_reset;
        int c;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++; if (out_sample !== 12'd2048) begin bad++; $display("FAIL reset_out_sample: got %0d required 2048", out_sample); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm_out: got %0b required 0", pwm_out); end
        total++; if (out_tick !== 1'b0) begin bad++; $display("FAIL reset_out_tick: got %0b required 0", out_tick); end
        total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL reset_seq_error: got %0b required 0", seq_error); end
        count_high(c);
        total++; if (c != 2048) begin bad++; $display("FAIL silence_duty: high %0d cycles required 2048", c); end
    endtask

    task automatic test_mix;
        int rc;
        send_frame(100, -50, 511, -512);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mix_hold_ready: got %0b required 0", in_ready); end
        total++; if (out_sample !== 12'd2048) begin bad++; $display("FAIL mix_before_wrap: got %0d required 2048", out_sample); end
        wait_tick(rc);
        total++; if (rc != 0) begin bad++; $display("FAIL mix_ready_in_hold: ready for %0d cycles required 0", rc); end
        total++; if (out_sample !== 12'h831) begin bad++; $display("FAIL mix_out_sample: got 0x%0h required 0x831", out_sample); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mix_ready_after_wrap: got %0b required 1", in_ready); end
        @(negedge clk);
        total++; if (out_tick !== 1'b0) begin bad++; $display("FAIL mix_tick_width: got %0b required 0", out_tick); end
    endtask

    task automatic test_extremes;
        int rc;
        int c;
        send_frame(511, 511, 511, 511);
        wait_tick(rc);
        total++; if (out_sample !== 12'd4092) begin bad++; $display("FAIL max_out_sample: got %0d required 4092", out_sample); end
        count_high(c);
        total++; if (c != 4092) begin bad++; $display("FAIL max_duty: high %0d cycles required 4092", c); end
        send_frame(-512, -512, -512, -512);
        wait_tick(rc);
        total++; if (out_sample !== 12'd0) begin bad++; $display("FAIL min_out_sample: got %0d required 0", out_sample); end
        count_high(c);
        total++; if (c != 0) begin bad++; $display("FAIL min_duty: high %0d cycles required 0", c); end
    endtask

    task automatic test_seq_error;
        int rc;
        send(2'd0, 5);
        send(2'd2, 7);
        total++; if (seq_error !== 1'b1) begin bad++; $display("FAIL seq_flag: got %0b required 1", seq_error); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL seq_ready: got %0b required 1", in_ready); end
        send_frame(1, 1, 1, 1);
        wait_tick(rc);
        total++; if (out_sample !== 12'd2052) begin bad++; $display("FAIL seq_recover: got %0d required 2052", out_sample); end
        send(2'd0, 5);
        send(2'd1, 3);
        send(2'd0, 7);
        send(2'd1, 1);
        send(2'd2, 1);
        send(2'd3, 1);
        wait_tick(rc);
        total++; if (out_sample !== 12'd2058) begin bad++; $display("FAIL seq_restart_ch0: got %0d required 2058", out_sample); end
        total++; if (seq_error !== 1'b1) begin bad++; $display("FAIL seq_sticky: got %0b required 1", seq_error); end
    endtask

    task automatic test_wrap_edge;
        int rc;
        int early;
        send_frame(0, 0, 0, 0);
        wait_tick(rc);
        total++; if (out_sample !== 12'd2048) begin bad++; $display("FAIL edge_setup: got %0d required 2048", out_sample); end
        // Counter reads 0 now; the 4096th posedge from here samples it at its maximum.
        send(2'd0, 10);
        send(2'd1, 20);
        send(2'd2, 30);
        repeat (4092) @(negedge clk);
        send(2'd3, 40);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL edge_hold: in_ready got %0b required 0", in_ready); end
        early = 0;
        for (int i = 1; i < 4096; i++) begin
            @(negedge clk);
            if (out_tick || out_sample !== 12'd2048) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL edge_early_update: %0d cycles changed, required 0", early); end
        @(negedge clk);
        total++; if (out_tick !== 1'b1) begin bad++; $display("FAIL edge_tick: got %0b required 1", out_tick); end
        total++; if (out_sample !== 12'd2148) begin bad++; $display("FAIL edge_out_sample: got %0d required 2148", out_sample); end
    endtask

    task automatic test_reset_hold;
        int changes;
        send_frame(100, -50, 511, -512);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rh_in_hold: in_ready got %0b required 0", in_ready); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (out_sample !== 12'd2048) begin bad++; $display("FAIL rh_out_sample: got %0d required 2048", out_sample); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rh_in_ready: got %0b required 1", in_ready); end
        total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL rh_seq_error: got %0b required 0", seq_error); end
        changes = 0;
        repeat (4200) begin
            @(negedge clk);
            if (out_tick || out_sample !== 12'd2048) changes++;
        end
        total++; if (changes != 0) begin bad++; $display("FAIL rh_discard: %0d cycles with tick/update, required 0", changes); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_mix;
        test_extremes;
        test_seq_error;
        test_wrap_edge;
        test_reset_hold;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
